// File: rtl/vram_state_writer_pkg.sv
// Shared VRAM map and word types for the display-state image.
// Used by the writer and by anything that reads the image back.
package my_pkg;

   localparam int VRAM_DW = 32;
   localparam int VRAM_AW = 12;
   localparam int NUM_BOARD_ROWS = 20;
   localparam int SCORE_W = 24;

   localparam logic [VRAM_AW-1:0] level_lines_addr = 12'd0;
   localparam logic [VRAM_AW-1:0] score_addr = 12'd1;
   localparam logic [VRAM_AW-1:0] row_0_addr = 12'd2;
   localparam logic [VRAM_AW-1:0] next_addr = 12'd22;

   typedef enum logic [2:0] {
      EMPTY, I, O, T, S, Z, J, L
   } cell_t;

   typedef logic [VRAM_DW-1:0] vram_word_t;

endpackage

// File: rtl/vram_state_writer_if.sv
// Request, board-store read port and VRAM write port of the writer.
// master = writer side, slave = game logic / board store / VRAM side.
interface vram_state_writer_if;
   import my_pkg::*;

   logic update_start;
   logic [SCORE_W-1:0] score_bin;
   logic [13:0] lines_bin;
   logic [6:0] level_bin;
   logic [2:0] next_piece;
   logic busy;
   logic update_done;
   logic [4:0] brd_rd_row;
   logic [29:0] brd_rd_data;
   logic vblank;
   logic vram_we;
   logic [VRAM_AW-1:0] vram_addr;
   vram_word_t vram_wdata;

   modport master (
      input update_start, score_bin, lines_bin, level_bin,
      input next_piece, brd_rd_data, vblank,
      output busy, update_done, brd_rd_row,
      output vram_we, vram_addr, vram_wdata
   );

   modport slave (
      output update_start, score_bin, lines_bin, level_bin,
      output next_piece, brd_rd_data, vblank,
      input busy, update_done, brd_rd_row,
      input vram_we, vram_addr, vram_wdata
   );

endinterface

// File: rtl/vram_state_writer_bin2bcd.sv
// Iterative double-dabble: load on start, one shift per cycle.
// bcd shows the value after the current shift; it is final while done=1.
module bin2bcd_seq #(
   parameter int BIN_W = 24,
   parameter int DIGITS = 8
) (
   input logic Clk,
   input logic Reset,
   input logic start,
   input logic [BIN_W-1:0] bin,
   output logic [4*DIGITS-1:0] bcd,
   output logic done
);
   localparam int CW = $clog2(BIN_W + 1);

   logic [BIN_W-1:0] sh_q;
   logic [4*DIGITS-1:0] bcd_q;
   logic [4*DIGITS-1:0] adj;
   logic [CW-1:0] cnt_q;
   logic run_q;

   always_comb begin
      adj = bcd_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_q[4*d +: 4] > 4'd4)
            adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
   end

   assign bcd = {adj[4*DIGITS-2:0], sh_q[BIN_W-1]};
   assign done = run_q && (cnt_q == CW'(BIN_W - 1));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sh_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         sh_q <= bin;
         bcd_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         sh_q <= sh_q << 1;
         bcd_q <= bcd;
         cnt_q <= cnt_q + 1'b1;
         if (done)
            run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/vram_state_writer.sv
// Builds the 23-word display-state image in VRAM on each update request.
// Conversions run freely; every VRAM write waits for vblank.
import my_pkg::*;

module vram_state_writer #(
   parameter int BIN_W = SCORE_W,
   parameter int NUM_ROWS = NUM_BOARD_ROWS
) (
   input logic Clk,
   input logic Reset,
   vram_state_writer_if.master bus
);
   typedef enum logic [3:0] {
      IDLE, CONV_SCORE, CONV_LINES, CONV_LEVEL,
      WR_LL, WR_SCORE, RD_ROW, WR_ROW, WR_NEXT, DONE
   } state_t;

   state_t state_q, state_d;
   logic pending_q, conv_start_q, conv_enter, go;
   logic [BIN_W-1:0] score_q, conv_bin;
   logic [13:0] lines_q;
   logic [6:0] level_q;
   logic [2:0] next_q;
   logic [4:0] row_q;
   logic [31:0] score_bcd_q, conv_bcd;
   logic [15:0] lines_bcd_q, level_bcd_q;
   logic conv_done, last_row;

   assign last_row = (row_q == 5'(NUM_ROWS - 1));
   assign go = (state_q == IDLE && bus.update_start)
            || (state_q == DONE && (pending_q || bus.update_start));
   assign conv_enter = (state_d != state_q)
                    && (state_d == CONV_SCORE || state_d == CONV_LINES
                        || state_d == CONV_LEVEL);

   always_comb begin
      conv_bin = score_q;
      if (state_q == CONV_LINES)
         conv_bin = BIN_W'(lines_q);
      else if (state_q == CONV_LEVEL)
         conv_bin = BIN_W'(level_q);
   end

   bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(8)) u_conv (
      .Clk(Clk),
      .Reset(Reset),
      .start(conv_start_q),
      .bin(conv_bin),
      .bcd(conv_bcd),
      .done(conv_done)
   );

   always_comb begin
      state_d = state_q;
      bus.vram_we = 1'b0;
      bus.vram_addr = '0;
      bus.vram_wdata = '0;
      bus.update_done = 1'b0;
      unique case (state_q)
         IDLE: if (go) state_d = CONV_SCORE;
         CONV_SCORE: if (conv_done) state_d = CONV_LINES;
         CONV_LINES: if (conv_done) state_d = CONV_LEVEL;
         CONV_LEVEL: if (conv_done) state_d = WR_LL;
         WR_LL: begin
            bus.vram_we = bus.vblank;
            bus.vram_addr = level_lines_addr;
            bus.vram_wdata = {lines_bcd_q, level_bcd_q};
            if (bus.vblank) state_d = WR_SCORE;
         end
         WR_SCORE: begin
            bus.vram_we = bus.vblank;
            bus.vram_addr = score_addr;
            bus.vram_wdata = score_bcd_q;
            if (bus.vblank) state_d = RD_ROW;
         end
         RD_ROW: state_d = WR_ROW;
         WR_ROW: begin
            bus.vram_we = bus.vblank;
            bus.vram_addr = row_0_addr + 12'(row_q);
            bus.vram_wdata = {2'b0, bus.brd_rd_data};
            if (bus.vblank) state_d = last_row ? WR_NEXT : RD_ROW;
         end
         WR_NEXT: begin
            bus.vram_we = bus.vblank;
            bus.vram_addr = next_addr;
            bus.vram_wdata = {29'b0, next_q};
            if (bus.vblank) state_d = DONE;
         end
         DONE: begin
            bus.update_done = 1'b1;
            state_d = go ? CONV_SCORE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy = (state_q != IDLE);
   // row_q holds through a stalled WR_ROW so the store keeps the same row
   assign bus.brd_rd_row = row_q;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         pending_q <= 1'b0;
         conv_start_q <= 1'b0;
         row_q <= '0;
         score_q <= '0;
         lines_q <= '0;
         level_q <= '0;
         next_q <= '0;
         score_bcd_q <= '0;
         lines_bcd_q <= '0;
         level_bcd_q <= '0;
      end else begin
         state_q <= state_d;
         conv_start_q <= conv_enter;
         if (go) begin
            pending_q <= 1'b0;
            score_q <= BIN_W'(bus.score_bin);
            lines_q <= bus.lines_bin;
            level_q <= bus.level_bin;
            next_q <= bus.next_piece;
            row_q <= '0;
         end else if (state_q != IDLE && bus.update_start) begin
            pending_q <= 1'b1;
         end
         if (conv_done && state_q == CONV_SCORE)
            score_bcd_q <= conv_bcd;
         if (conv_done && state_q == CONV_LINES)
            lines_bcd_q <= (lines_q > 14'd9999) ? 16'h9999 : conv_bcd[15:0];
         if (conv_done && state_q == CONV_LEVEL)
            level_bcd_q <= conv_bcd[15:0];
         if (state_q == WR_ROW && bus.vblank)
            row_q <= last_row ? 5'd0 : row_q + 5'd1;
      end
   end

endmodule

// File: tb/tb_vram_state_writer.sv
// Directed bench for vram_state_writer with a write scoreboard.
// Timing is counted in cycles after the edge that accepts a request.
module tb_vram_state_writer;
   import my_pkg::*;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   vram_state_writer_if bus ();

   vram_state_writer dut (
      .Clk(Clk),
      .Reset(Reset),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   logic [29:0] board [32];
   always_ff @(posedge Clk) bus.brd_rd_data <= board[bus.brd_rd_row];

   int compared = 0;
   int mismatched = 0;
   wr_t exp_q[$];
   int edges = 0;
   int t0 = 0;
   int wr_cnt, done_cnt, done_at, last_wr, busy_low, row9_wr;
   int cur_ln, cur_lv, cur_np;
   logic [4:0] prev_row = '0;

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      int iv;
      wr_t e;
      @(negedge Clk);
      iv = edges - t0 + 1;
      if (!bus.vblank && !Reset)
         check("we_gated", 64'(bus.vram_we), 64'd0);
      if (bus.vram_we) begin
         wr_cnt++;
         last_wr = iv;
         if (bus.vram_addr == 12'd9) row9_wr++;
         if (bus.vram_addr >= 12'd2 && bus.vram_addr < 12'd22)
            check("rd_row", 64'(prev_row), 64'(bus.vram_addr - 12'd2));
         if (exp_q.size() == 0) begin
            check("extra_wr", 64'(bus.vram_addr), 64'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            check("vram_wr", {20'd0, bus.vram_addr, bus.vram_wdata},
                  {20'd0, e.addr, e.data});
         end
      end
      if (bus.update_done) begin
         done_cnt++;
         done_at = iv;
      end
      if (!bus.busy) busy_low++;
      prev_row = bus.brd_rd_row;
      @(posedge Clk);
      edges++;
      #1;
   endtask

   task automatic push_pass(input int sc, input int ln, input int lv,
                            input int np);
      wr_t e;
      logic [31:0] lb, vb;
      lb = to_bcd(ln);
      vb = to_bcd(lv);
      if (ln > 9999) lb = 32'h9999;
      e.addr = 12'd0;
      e.data = {lb[15:0], vb[15:0]};
      exp_q.push_back(e);
      e.addr = 12'd1;
      e.data = to_bcd(sc);
      exp_q.push_back(e);
      for (int r = 0; r < 20; r++) begin
         e.addr = 12'(2 + r);
         e.data = {2'b0, board[r]};
         exp_q.push_back(e);
      end
      e.addr = 12'd22;
      e.data = {29'b0, 3'(np)};
      exp_q.push_back(e);
   endtask

   task automatic start(input int sc, input int ln, input int lv,
                        input int np);
      bus.score_bin = 24'(sc);
      bus.lines_bin = 14'(ln);
      bus.level_bin = 7'(lv);
      bus.next_piece = 3'(np);
      cur_ln = ln;
      cur_lv = lv;
      cur_np = np;
      push_pass(sc, ln, lv, np);
      wr_cnt = 0;
      done_cnt = 0;
      done_at = 0;
      last_wr = 0;
      row9_wr = 0;
      bus.update_start = 1'b1;
      step();
      bus.update_start = 1'b0;
      t0 = edges;
      busy_low = 0;
   endtask

   // ndone=0 runs exactly up to cycle `budget` with no timeout check
   task automatic run(input int ndone, input int lo, input int hi,
                      input int p1, input int p2, input int budget);
      int k;
      k = edges - t0 + 1;
      while ((ndone == 0 || done_cnt < ndone) && k <= budget) begin
         bus.vblank = !(k >= lo && k <= hi);
         bus.update_start = (k == p1 || k == p2);
         if (k == p1) begin
            bus.score_bin = 24'd1;
            push_pass(1, cur_ln, cur_lv, cur_np);
         end
         step();
         k = edges - t0 + 1;
      end
      bus.vblank = 1'b1;
      bus.update_start = 1'b0;
      if (ndone > 0 && done_cnt < ndone)
         check("timeout", 64'(done_cnt), 64'(ndone));
   endtask

   initial begin
      int bl;
      bus.update_start = 1'b0;
      bus.score_bin = '0;
      bus.lines_bin = '0;
      bus.level_bin = '0;
      bus.next_piece = '0;
      bus.vblank = 1'b1;
      for (int r = 0; r < 32; r++) board[r] = 30'(r * 3 + 1);

      step();
      step();
      check("reset_out",
            64'({bus.busy, bus.update_done, bus.vram_we, bus.vram_addr,
                 bus.vram_wdata, bus.brd_rd_row}), 64'd0);
      Reset = 1'b0;
      step();

      // basic pass and board rows
      start(123456, 42, 7, 5);
      run(1, 0, 0, -1, -1, 200);
      check("t1_wr_cnt", 64'(wr_cnt), 64'd23);
      check("t1_last_wr", 64'(last_wr), 64'd118);
      check("t1_done_at", 64'(done_at), 64'd119);
      check("t1_q_left", 64'(exp_q.size()), 64'd0);
      step();
      check("t1_busy_off", 64'(bus.busy), 64'd0);

      // saturation and largest values
      for (int r = 0; r < 20; r++) board[r] = 30'($urandom);
      start(16777215, 12000, 127, 7);
      run(1, 0, 0, -1, -1, 200);
      check("t3_wr_cnt", 64'(wr_cnt), 64'd23);
      check("t3_q_left", 64'(exp_q.size()), 64'd0);
      step();

      // vblank low for 10 cycles on row 7
      start(0, 0, 0, 0);
      run(1, 93, 102, -1, -1, 250);
      check("t4_wr_cnt", 64'(wr_cnt), 64'd23);
      check("t4_row7_once", 64'(row9_wr), 64'd1);
      check("t4_done_at", 64'(done_at), 64'd129);
      check("t4_q_left", 64'(exp_q.size()), 64'd0);
      step();

      // coalesced re-requests during rows 3 and 9
      start(4321, 9999, 1, 3);
      run(2, 0, 0, 85, 97, 400);
      bl = busy_low;
      check("t5_busy_cont", 64'(bl), 64'd0);
      check("t5_done_at", 64'(done_at), 64'd238);
      for (int i = 0; i < 6; i++) step();
      check("t5_done_cnt", 64'(done_cnt), 64'd2);
      check("t5_wr_cnt", 64'(wr_cnt), 64'd46);
      check("t5_q_left", 64'(exp_q.size()), 64'd0);

      // reset while row 12 is being written
      start(777, 55, 3, 2);
      run(0, 0, 0, -1, -1, 102);
      Reset = 1'b1;
      #1;
      check("t6_rst_we", 64'({bus.vram_we, bus.busy}), 64'd0);
      check("t6_q_left", 64'(exp_q.size()), 64'd9);
      exp_q.delete();
      bl = wr_cnt;
      step();
      step();
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("t6_no_wr", 64'(wr_cnt), 64'(bl));
      start(98765, 300, 12, 6);
      run(1, 0, 0, -1, -1, 200);
      check("t6_wr_cnt", 64'(wr_cnt), 64'd23);
      check("t6_done_at", 64'(done_at), 64'd119);
      check("t6_q_left", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
